ee357_mcpu_mem_if: RTL and testbench

EE357_MCPU_MEM_IF -- requirements
Module: ee357_mcpu_mem_if

---
 rtl/ee357_mcpu_pkg.sv | 24 ++
 rtl/ee357_mcpu_wait_ctr.sv | 29 ++
 rtl/ee357_mcpu_mem_if.sv | 127 ++++++++++++
 tb/tb_ee357_mcpu_mem_if.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ee357_mcpu_pkg.sv
// Shared types and constants for the EE357 multicycle CPU memory interface.
// MCPU_MEM_ALIGN_CHK_EN (optional) enables misaligned-address rejection in the memory interface.
package ee357_mcpu_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 30;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Primary opcode field values, ir[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

endpackage

// File: rtl/ee357_mcpu_wait_ctr.sv
// Saturating wait-cycle counter; expired is high once LIMIT_CYCLES-1 un-acked cycles have elapsed.
module ee357_mcpu_wait_ctr #(
    parameter int LIMIT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (LIMIT_CYCLES > 1) ? $clog2(LIMIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT_CYCLES - 1);

    logic [CW-1:0] count;

    // expired flags the final allowed cycle so the timeout lands on that edge
    assign expired = (count == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ee357_mcpu_mem_if.sv
// Multicycle CPU memory interface: one access at a time, IR/MDR capture, timeout abandon.
// Optional build macro: MCPU_MEM_ALIGN_CHK_EN (rejects misaligned word accesses).
module ee357_mcpu_mem_if
    import ee357_mcpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mr,
    input  logic              mw,
    input  logic              iord,
    input  logic              irw,
    input  logic [WORD_W-1:0] pc,
    input  logic [WORD_W-1:0] alu_out,
    input  logic [WORD_W-1:0] wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [WORD_W-1:0] ir,
    output logic [WORD_W-1:0] mdr,
    output logic              busy,
    output logic              err,
    output state_t            dbg_state
);
    // Handshake: mem_req rises on acceptance and holds mem_we/mem_addr/mem_wdata stable
    // until a one-cycle mem_ack (or timeout) is seen in WAIT; it drops on the following edge.

    state_t            state_q, state_d;
    logic [WORD_W-1:0] sel_addr;
    logic              cmd, misaligned, accept, reject, ack_hit, timeout, expired;
    logic              irw_q;

    assign sel_addr  = iord ? alu_out : pc;
    assign cmd       = mr | mw;
    assign dbg_state = state_q;

`ifdef MCPU_MEM_ALIGN_CHK_EN
    assign misaligned = |sel_addr[1:0];
`else
    logic unused_low;
    assign misaligned = 1'b0;
    assign unused_low = ^sel_addr[1:0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        ack_hit = 1'b0;
        timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd) begin
                    if (misaligned) begin
                        reject  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        accept  = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    ack_hit = 1'b1;
                    state_d = ST_DONE;
                end else if (expired) begin
                    timeout = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    ee357_mcpu_wait_ctr #(
        .LIMIT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_ctr (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable ((state_q == ST_WAIT) && !mem_ack),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            irw_q     <= 1'b0;
            ir        <= '0;
            mdr       <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            busy <= (state_d == ST_WAIT);
            // a simultaneous mr+mw is served as a read but still flagged
            err  <= reject | timeout | (accept & mr & mw);
            if (accept) begin
                mem_req   <= 1'b1;
                mem_we    <= mw & ~mr;
                mem_addr  <= sel_addr[WORD_W-1:2];
                mem_wdata <= wdata;
                irw_q     <= irw;
            end else if (ack_hit || timeout) begin
                mem_req <= 1'b0;
            end
            if (ack_hit && !mem_we) begin
                mdr <= mem_rdata;
                if (irw_q) ir <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ee357_mcpu_mem_if.sv
// Bench for ee357_mcpu_mem_if: directed scenarios plus random traffic against a transaction model.
module tb_ee357_mcpu_mem_if;
    import ee357_mcpu_pkg::*;

    localparam int TIMEOUT = 16;
`ifdef MCPU_MEM_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic        mr = 0, mw = 0, iord = 0, irw = 0, mem_ack = 0;
    logic [31:0] pc = 0, alu_out = 0, wdata = 0, mem_rdata = 0;
    logic        mem_req, mem_we, busy, err;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, ir, mdr;
    state_t      dbg_state;

    ee357_mcpu_mem_if #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .mr(mr), .mw(mw), .iord(iord), .irw(irw),
        .pc(pc), .alu_out(alu_out), .wdata(wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .ir(ir), .mdr(mdr), .busy(busy), .err(err), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 waiting for ack, 2 finishing
    int          m_phase, m_waited;
    logic        m_req, m_we, m_irw, m_err;
    logic [29:0] m_addr;
    logic [31:0] m_wdata, m_ir, m_mdr, m_sel;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0; m_waited = 0; m_req = 0; m_we = 0; m_irw = 0; m_err = 0;
            m_addr = 0; m_wdata = 0; m_ir = 0; m_mdr = 0;
        end else begin
            m_err = 0;
            case (m_phase)
                0: if (mr || mw) begin
                    m_sel = iord ? alu_out : pc;
                    if (ALIGN_CHK && (m_sel % 4 != 0)) begin
                        m_phase = 2;
                        m_err   = 1;
                    end else begin
                        m_phase  = 1;
                        m_req    = 1;
                        m_we     = mw && !mr;
                        m_addr   = 30'(m_sel >> 2);
                        m_wdata  = wdata;
                        m_irw    = irw;
                        m_waited = 0;
                        m_err    = mr && mw;
                    end
                end
                1: if (mem_ack) begin
                    if (!m_we) begin
                        m_mdr = mem_rdata;
                        if (m_irw) m_ir = mem_rdata;
                    end
                    m_req   = 0;
                    m_phase = 2;
                end else begin
                    m_waited++;
                    if (m_waited == TIMEOUT) begin
                        m_req   = 0;
                        m_err   = 1;
                        m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    int busy_cycles = 0;
    always @(negedge clk) begin
        chk("state",     32'(dbg_state), 32'(m_phase));
        chk("mem_req",   32'(mem_req),   32'(m_req));
        chk("busy",      32'(busy),      32'(m_phase == 1));
        chk("err",       32'(err),       32'(m_err));
        chk("mem_we",    32'(mem_we),    32'(m_we));
        chk("mem_addr",  32'(mem_addr),  32'(m_addr));
        chk("mem_wdata", mem_wdata,      m_wdata);
        chk("ir",        ir,             m_ir);
        chk("mdr",       mdr,            m_mdr);
        if (busy) busy_cycles++;
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        mr = 0; mw = 0; mem_ack = 0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    int req_cnt, err_cnt;

    initial begin
        cycles(3);
        chk("rst_ir",   ir, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1;
        cycles(2);

        // fetch: ack in the third WAIT cycle
        iord = 0; pc = 32'h0000_0040; mr = 1; irw = 1; busy_cycles = 0;
        @(negedge clk); mr = 0;
        chk("fetch_addr", 32'(mem_addr), 32'h10);
        chk("fetch_req",  32'(mem_req),  32'h1);
        @(negedge clk);
        @(negedge clk); mem_ack = 1; mem_rdata = 32'h8C22_0004;
        @(negedge clk); mem_ack = 0;
        chk("fetch_ir",   ir, 32'h8C22_0004);
        chk("fetch_op",   32'(ir[31:26]), 32'(OP_LW));
        cycles(2);
        chk("fetch_busy", busy_cycles, 3);

        // store: ack after one cycle, ir/mdr untouched
        iord = 1; alu_out = 32'h100; wdata = 32'hDEAD_BEEF; mw = 1; irw = 1;
        @(negedge clk); mw = 0;
        chk("store_we",    32'(mem_we),   32'h1);
        chk("store_addr",  32'(mem_addr), 32'h40);
        chk("store_wdata", mem_wdata,     32'hDEAD_BEEF);
        mem_ack = 1; mem_rdata = 32'h1234_5678;
        @(negedge clk); mem_ack = 0;
        chk("store_ir",  ir,  32'h8C22_0004);
        chk("store_mdr", mdr, 32'h8C22_0004);
        cycles(2);

        // timeout: no ack
        iord = 0; pc = 32'h80; mr = 1; irw = 0;
        @(negedge clk); mr = 0;
        req_cnt = 0; err_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            if (mem_req) req_cnt++;
            if (err) err_cnt++;
            @(negedge clk);
        end
        chk("to_req_cycles", req_cnt, 16);
        chk("to_err_pulses", err_cnt, 1);
        chk("to_mdr", mdr, 32'h8C22_0004);

        // simultaneous mr+mw: read with err pulse
        iord = 0; pc = 32'h44; mr = 1; mw = 1; irw = 0;
        @(negedge clk); idle_inputs();
        chk("rw_err", 32'(err), 32'h1);
        chk("rw_we",  32'(mem_we), 32'h0);
        mem_ack = 1; mem_rdata = 32'h0BAD_CAFE;
        @(negedge clk); mem_ack = 0;
        chk("rw_mdr", mdr, 32'h0BAD_CAFE);
        cycles(2);

        // reset in the third WAIT cycle
        iord = 0; pc = 32'h200; mr = 1;
        @(negedge clk); mr = 0;
        cycles(2);
        #2 rst = 0;
        #1;
        chk("rst_mid_req",  32'(mem_req), 32'h0);
        chk("rst_mid_busy", 32'(busy),    32'h0);
        @(negedge clk); rst = 1; mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk); mem_ack = 0;
        chk("rst_late_ack_mdr", mdr, 32'h0);
        chk("rst_late_ack_req", 32'(mem_req), 32'h0);
        cycles(2);

        // alignment
        iord = 1; alu_out = 32'h102; mr = 1; irw = 0;
        @(negedge clk); mr = 0;
        if (ALIGN_CHK) begin
            chk("align_req", 32'(mem_req), 32'h0);
            chk("align_err", 32'(err),     32'h1);
        end else begin
            chk("align_req",  32'(mem_req),  32'h1);
            chk("align_addr", 32'(mem_addr), 32'h40);
            mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
            @(negedge clk); mem_ack = 0;
            chk("align_mdr", mdr, 32'hCAFE_F00D);
        end
        cycles(3);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            mr        = ($urandom_range(0, 3) == 0);
            mw        = ($urandom_range(0, 4) == 0);
            iord      = 1'($urandom_range(0, 1));
            irw       = 1'($urandom_range(0, 1));
            pc        = $urandom;
            alu_out   = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                pc[1:0] = 2'b00; alu_out[1:0] = 2'b00;
            end
            wdata     = $urandom;
            mem_rdata = $urandom;
            mem_ack   = ($urandom_range(0, 5) == 0);
            if (i == 700) begin
                #2 rst = 0;
                @(negedge clk); #2 rst = 1;
            end
            @(negedge clk);
        end
        idle_inputs();
        cycles(TIMEOUT + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
